report_scheduler: RTL

Sequencer that turns the temperature readout into periodic ASCII reports on the serial link. It sits between the temperature-to-BCD conversion and a byte-wide UART transmitter. Reports fire on an internal period timer or on a user request. Each report snapshots the current sign and BCD digits and streams one fixed-format frame (e.g. `+23.5`) to the transmitter over a valid/ready handshake.

---
 rtl/report_scheduler_if.sv | 12 +
 rtl/report_scheduler.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/report_scheduler_if.sv
// Byte stream from report_scheduler to the UART transmitter.
// Master drives tx_data/tx_valid; slave answers with tx_ready.
interface report_scheduler_if;
  // Handshake: a byte transfers in any cycle where tx_valid & tx_ready are both
  // high. Once tx_valid rises, tx_valid and tx_data hold until that transfer.
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/report_scheduler.sv
// Periodic / on-request ASCII temperature report framer ("+23.5" + terminator).
// Optional macro REPORT_CRLF_EN: terminate frames with CR LF instead of LF.
module report_scheduler #(
  parameter int CLK_HZ    = 100000000,
  parameter int PERIOD_MS = 1000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      req,
  input  logic                      neg,
  input  logic [3:0]                d2,
  input  logic [3:0]                d1,
  input  logic [3:0]                d0,
  report_scheduler_if.master        tx,
  output logic                      busy,
  output logic [15:0]               frame_cnt,
  output logic                      dbg_state
);

  localparam int PERIOD_CYC = CLK_HZ / 1000 * PERIOD_MS;
  localparam int TW         = $clog2(PERIOD_CYC);
  localparam logic [TW-1:0] TIMER_LAST = TW'(PERIOD_CYC - 1);

`ifdef REPORT_CRLF_EN
  localparam int FRAME_LEN = 7;
`else
  localparam int FRAME_LEN = 6;
`endif
  localparam logic [2:0] LAST_IDX = 3'(FRAME_LEN - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic          tick;
  logic          trigger;
  logic          start;
  logic          pending;
  logic [2:0]    idx;
  logic          snap_neg;
  logic [3:0]    snap_d2;
  logic [3:0]    snap_d1;
  logic [3:0]    snap_d0;

  function automatic logic [7:0] digit_char(input logic [3:0] d);
    return (d > 4'd9) ? 8'h3F : {4'h3, d};
  endfunction

  function automatic logic [7:0] frame_byte(input logic [2:0] i, input logic s,
                                            input logic [3:0] a, input logic [3:0] b,
                                            input logic [3:0] c);
    logic [7:0] r;
    case (i)
      3'd0:    r = s ? 8'h2D : 8'h2B;
      3'd1:    r = digit_char(a);
      3'd2:    r = digit_char(b);
      3'd3:    r = 8'h2E;
      3'd4:    r = digit_char(c);
`ifdef REPORT_CRLF_EN
      3'd5:    r = 8'h0D;
`else
      3'd5:    r = 8'h0A;
`endif
      default: r = 8'h0A;
    endcase
    return r;
  endfunction

  assign tick    = en && (timer == TIMER_LAST);
  assign trigger = en && (tick || req);
  assign start   = trigger || (en && pending);

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      timer <= '0;
    end else if (tick) begin
      timer <= '0;
    end else begin
      timer <= timer + 1'b1;
    end
  end

  // Any trigger seen in IDLE starts a frame at once, so only triggers that
  // arrive while sending are remembered; extras collapse into one.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      pending <= 1'b0;
    end else if (state == IDLE) begin
      pending <= 1'b0;
    end else if (trigger) begin
      pending <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= '0;
      snap_neg    <= 1'b0;
      snap_d2     <= '0;
      snap_d1     <= '0;
      snap_d0     <= '0;
      tx.tx_valid <= 1'b0;
      tx.tx_data  <= 8'h00;
      frame_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state       <= SEND;
            idx         <= '0;
            snap_neg    <= neg;
            snap_d2     <= d2;
            snap_d1     <= d1;
            snap_d0     <= d0;
            tx.tx_valid <= 1'b1;
            tx.tx_data  <= frame_byte(3'd0, neg, d2, d1, d0);
          end
        end
        SEND: begin
          if (tx.tx_valid && tx.tx_ready) begin
            if (idx == LAST_IDX) begin
              state       <= IDLE;
              tx.tx_valid <= 1'b0;
              tx.tx_data  <= 8'h00;
              frame_cnt   <= frame_cnt + 16'd1;
            end else begin
              idx        <= idx + 3'd1;
              tx.tx_data <= frame_byte(idx + 3'd1, snap_neg, snap_d2, snap_d1, snap_d0);
            end
          end
        end
        default: begin
          state       <= IDLE;
          tx.tx_valid <= 1'b0;
          tx.tx_data  <= 8'h00;
        end
      endcase
    end
  end

  assign busy      = (state == SEND);
  assign dbg_state = state;

endmodule
